// File: rtl/rand_arbiter.sv
// -----------------------------------------------------------------------------
// rand_arbiter
//   Round-robin arbiter that hands each granted requester a random number drawn
//   from an 8-bit XNOR LFSR. A draw shifts the LFSR STEPS times and then
//   delivers the top OUT_W bits together with the one-hot grant.
//
// Parameters
//   STEPS  LFSR shifts per draw (1..15)
//   OUT_W  width of randnum (1..8)
//
// Ports
//   clock      in   rising-edge clock for all state
//   reset      in   synchronous active-high reset
//   seed       in   16-bit seed, folded to 8 bits on reset / seed_load
//   seed_load  in   reseed strobe, honoured only while idle
//   req        in   level request per requester (bit i = requester i)
//   grant      out  one-hot owner of the current draw, 0 when idle
//   randnum    out  delivered random value, held between draws
//   valid      out  one-cycle pulse marking randnum/grant valid
//   busy       out  high while a draw is in progress
// -----------------------------------------------------------------------------
module rand_arbiter #(
  parameter int unsigned STEPS = 4,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      seed,
  input  logic             seed_load,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [OUT_W-1:0] randnum,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       lfsr_q;
  logic [3:0]       cnt_q;
  logic [1:0]       last_q;
  logic [1:0]       gidx_q;
  logic [3:0]       grant_q;
  logic [OUT_W-1:0] randnum_q;
  logic             valid_q;
  logic             busy_q;
  logic [1:0]       pick_d;

  // Fold the 16-bit seed to 8 bits; all-ones is the XNOR lockup state, so
  // it is replaced with 8'hFE.
  function automatic logic [7:0] seed_fold(input logic [15:0] s);
    logic [7:0] f;
    f = s[15:8] ^ s[7:0];
    if (f == 8'hFF) begin
      return 8'hFE;
    end else begin
      return f;
    end
  endfunction

  // One LFSR step: shift left, feed back XNOR of taps 7 and 3.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ~(v[7] ^ v[3])};
  endfunction

  // First asserted requester searching upward from last+1 (wrapping).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Round-robin winner for the current request vector.
  always_comb begin
    pick_d = rr_pick(req, last_q);
  end

  // Draw FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= seed_fold(seed);
      cnt_q     <= 4'd0;
      last_q    <= 2'd3;
      gidx_q    <= 2'd0;
      grant_q   <= 4'b0000;
      randnum_q <= {OUT_W{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (seed_load) begin
            // Reseed takes priority; a pending req is simply seen next cycle.
            lfsr_q  <= seed_fold(seed);
            grant_q <= 4'b0000;
          end else if (req != 4'b0000) begin
            gidx_q  <= pick_d;
            grant_q <= 4'b0001 << pick_d;
            cnt_q   <= 4'(STEPS);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            grant_q <= 4'b0000;
          end
        end
        SHIFT: begin
          lfsr_q <= lfsr_step(lfsr_q);
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          // grant is left in place so it is still valid alongside the pulse.
          randnum_q <= lfsr_q[7 -: OUT_W];
          valid_q   <= 1'b1;
          last_q    <= gidx_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 4'b0000;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign randnum = randnum_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rand_arbiter
//   Self-checking bench for rand_arbiter. A draw-level reference model predicts
//   grant/valid/busy/randnum every cycle; directed scenarios add literal
//   expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_rand_arbiter;

  localparam int STEPS = 4;
  localparam int OUT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [15:0]      seed;
  logic             seed_load;
  logic [3:0]       req;
  logic [3:0]       grant;
  logic [OUT_W-1:0] randnum;
  logic             valid;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  rand_arbiter #(.STEPS(STEPS), .OUT_W(OUT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .seed     (seed),
    .seed_load(seed_load),
    .req      (req),
    .grant    (grant),
    .randnum  (randnum),
    .valid    (valid),
    .busy     (busy)
  );

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] fold(input logic [15:0] s);
    logic [7:0] f;
    f = s[15:8] ^ s[7:0];
    return (f == 8'hFF) ? 8'hFE : f;
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[6:0], ~(x[7] ^ x[3])};
    return x;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  // ---------------- draw-level model ----------------
  logic [7:0]       m_lfsr;
  int               m_last;
  int               m_win;
  int               m_left;
  bit               m_active;
  logic [OUT_W-1:0] m_result;
  logic [3:0]       m_grant;
  logic             m_valid;
  logic             m_busy;
  logic [OUT_W-1:0] m_rand;

  // A draw started at edge e delivers at edge e+STEPS+1; the model computes
  // the delivered value when the draw starts.
  always @(posedge clock) begin
    if (reset) begin
      m_lfsr   <= fold(seed);
      m_last   <= 3;
      m_active <= 1'b0;
      m_grant  <= 4'b0000;
      m_valid  <= 1'b0;
      m_busy   <= 1'b0;
      m_rand   <= '0;
    end else if (m_active) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid  <= 1'b1;
        m_busy   <= 1'b0;
        m_rand   <= m_result;
        m_last   <= m_win;
        m_active <= 1'b0;
      end
    end else begin
      m_valid <= 1'b0;
      if (seed_load) begin
        m_lfsr  <= fold(seed);
        m_grant <= 4'b0000;
      end else if (req != 4'b0000) begin
        m_win    <= pick(req, m_last);
        m_grant  <= 4'b0001 << pick(req, m_last);
        m_active <= 1'b1;
        m_busy   <= 1'b1;
        m_left   <= STEPS + 1;
        m_lfsr   <= adv(m_lfsr, STEPS);
        m_result <= OUT_W'(adv(m_lfsr, STEPS) >> (8 - OUT_W));
      end else begin
        m_grant <= 4'b0000;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_grant",   32'(grant),   32'(m_grant));
      check("model_valid",   32'(valid),   32'(m_valid));
      check("model_busy",    32'(busy),    32'(m_busy));
      check("model_randnum", 32'(randnum), 32'(m_rand));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [15:0] s);
    reset = 1'b1;
    seed  = s;
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] exp_seq [5];
  int got;
  int vcount;

  initial begin
    reset     = 1'b1;
    seed      = 16'h000F;
    seed_load = 1'b0;
    req       = 4'b0000;
    tick();
    chk_en = 1'b1;
    check("rst_grant",   32'(grant),   32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_randnum", 32'(randnum), 32'h0);
    reset = 1'b0;

    // Pin the model helpers against hand-computed values.
    check("pin_adv_0F", 32'(adv(8'h0F, 4)), 32'hF0);
    check("pin_fold_FF", 32'(fold(16'h00FF)), 32'hFE);
    check("pin_adv_FE", 32'(adv(8'hFE, 4)), 32'hEE);
    check("pin_pick", 32'(pick(4'b1001, 0)), 32'd3);

    // Seed 000F, single draw for requester 0.
    req = 4'b0001;
    tick();
    req = 4'b0000;
    check("d1_busy_start", 32'(busy), 32'h1);
    check("d1_grant_start", 32'(grant), 32'h1);
    repeat (4) tick();
    check("d1_valid_early", 32'(valid), 32'h0);
    tick();
    check("d1_valid", 32'(valid), 32'h1);
    check("d1_randnum", 32'(randnum), 32'd7);
    check("d1_grant", 32'(grant), 32'h1);
    tick();
    check("d1_valid_drop", 32'(valid), 32'h0);

    // Seed 00FF folds to lockup, loaded as FE.
    do_reset(16'h00FF);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (4) tick();
    tick();
    check("d2_valid", 32'(valid), 32'h1);
    check("d2_randnum", 32'(randnum), 32'd7);

    // One-cycle pulse on requester 1 still completes.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    repeat (4) tick();
    tick();
    check("d3_valid", 32'(valid), 32'h1);
    check("d3_grant", 32'(grant), 32'h2);

    // Continuous full request: round-robin order.
    do_reset(16'h5A3C);
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    got = 0;
    for (int c = 0; c < 80 && got < 5; c++) begin
      tick();
      if (valid) begin
        check("rr_grant", 32'(grant), 32'(exp_seq[got]));
        got++;
      end
    end
    check("rr_count", 32'(got), 32'd5);
    req = 4'b0000;
    tick();

    // Reset during the 2nd SHIFT cycle aborts the draw.
    do_reset(16'h000F);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_grant", 32'(grant), 32'h0);
    check("abort_valid", 32'(valid), 32'h0);
    check("abort_randnum", 32'(randnum), 32'h0);
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);

    // seed_load + req in the same idle cycle: reseed first, grant next cycle.
    do_reset(16'h1234);
    seed      = 16'h000F;
    seed_load = 1'b1;
    req       = 4'b0100;
    tick();
    seed_load = 1'b0;
    check("sl_grant_defer", 32'(grant), 32'h0);
    check("sl_busy_defer", 32'(busy), 32'h0);
    tick();
    check("sl_grant", 32'(grant), 32'h4);
    req       = 4'b0000;
    seed      = 16'h1234;
    seed_load = 1'b1;
    repeat (4) tick();
    seed_load = 1'b0;
    tick();
    check("sl_valid", 32'(valid), 32'h1);
    check("sl_randnum", 32'(randnum), 32'd7);
    check("sl_grant_valid", 32'(grant), 32'h4);

    // Randomized phase; the model comparison runs every cycle.
    for (int c = 0; c < 4000; c++) begin
      req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      seed_load = ($urandom_range(0, 15) == 0);
      seed      = 16'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset     = 1'b0;
    seed_load = 1'b0;
    req       = 4'b0000;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 SHALL have parameter STEPS, default 4, meaning LFSR shifts per draw, legal range 1..15.
REQ-002 SHALL have parameter OUT_W, default 3, meaning randnum width, legal range 1..8.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port seed  input  16  seed value, sampled on reset or seed_load only.
REQ-006 SHALL have port seed_load  input  1  reseed strobe, honoured in IDLE only.
REQ-007 SHALL have port req  input  4  level request per requester; bit i is requester i.
REQ-008 SHALL have port grant  output  4  one-hot owner of the current draw; 0 when idle.
REQ-009 SHALL have port randnum  output  OUT_W  delivered random value.
REQ-010 SHALL have port valid  output  1  one-cycle pulse; randnum and grant are valid.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL hold an internal 8-bit LFSR: shift left, bit0 <= NOT(lfsr[7] XOR lfsr[3]).
REQ-013 SHALL load the LFSR with the fold seed[15:8] XOR seed[7:0], or with 8'hFE if the fold equals 8'hFF (XNOR lockup state).
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE, all outputs registered.
REQ-015 IDLE, seed_load=1: SHALL reload the LFSR per REQ-013 and stay in IDLE; any req in that cycle is deferred, not lost.
REQ-016 IDLE, seed_load=0, req!=0: SHALL select the first asserted requester searching from (last_grant+1) mod 4 upward, latch grant one-hot, load step counter = STEPS, and go to SHIFT.
REQ-017 IDLE, req=0: SHALL hold the LFSR unchanged (no free-running).
REQ-018 SHIFT: SHALL shift the LFSR once per cycle and decrement the counter; after exactly STEPS shifts, SHALL go to DONE.
REQ-019 DONE: SHALL drive randnum = lfsr[7:8-OUT_W], valid=1 for one cycle, set last_grant to the granted index, and return to IDLE.
REQ-020 SHALL assert valid on the (STEPS+1)-th rising edge after the edge at which req was sampled in IDLE; back-to-back draws have a 1-cycle IDLE gap.
REQ-021 SHALL hold grant constant from the SHIFT entry through the valid cycle, and clear grant to 0 in IDLE.
REQ-022 SHALL complete and deliver a draw even if the granted req bit drops mid-draw.
REQ-023 SHALL ignore seed_load while in SHIFT or DONE (no deferral).
REQ-024 SHALL hold randnum at its last delivered value between draws.
REQ-025 SHALL treat req bits for requesters other than the granted one as don't-care while busy.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, grant=0, valid=0, busy=0, randnum=0, last_grant=3 (requester 0 first), and load the LFSR per REQ-013 from the current seed; reset SHALL override every state, including mid-SHIFT and DONE.

Verification
REQ-027 STEPS=4, reset with seed=16'h000F, then req=4'b0001 -> LFSR 0F,1E,3C,78,F0; valid with grant=4'b0001, randnum=3'd7 on the 5th edge after sampling.
REQ-028 Reset with seed=16'h00FF (fold FF) -> LFSR loaded 8'hFE; one req=4'b0001 draw -> FD,FB,F7,EE; randnum=3'd7.
REQ-029 req=4'b1111 held continuously -> grant sequence 0001,0010,0100,1000,0001 on successive valid pulses, each valid one cycle wide.
REQ-030 reset asserted during the 2nd SHIFT cycle -> next cycle busy=0, grant=0, valid=0, randnum=0; no valid pulse for the aborted draw.
REQ-031 seed_load with seed=16'h000F and req=4'b0100 in the same IDLE cycle -> LFSR=0F, no grant that cycle; grant=4'b0100 on the next cycle; seed_load while busy -> LFSR sequence unaffected.
REQ-032 req=4'b0010 pulsed for one cycle only -> draw still completes; valid with grant=4'b0010 after STEPS+1 edges.
